// File: rtl/aes_sub_bytes.sv
// ============================================================================
//  Module   : aes_sub_bytes
//  Brief    : AES SubBytes / InvSubBytes over a 128-bit state, one registered
//             pipeline step, mode selectable per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sub_bytes (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         fwd_ninv_i,
    input  logic [127:0] in_state,
    output logic [127:0] out_state
);

    localparam logic [7:0] c_gf_poly_lo = 8'h1B;
    localparam logic [7:0] c_aff_const  = 8'h63;
    localparam logic [7:0] c_iaff_const = 8'h05;

    // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? c_gf_poly_lo : 8'h00);
        end
        return acc;
    endfunction

    // b^254 = b^-1 for b != 0, and maps 0 to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = b;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ c_aff_const;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        return {b[6:0], b[7]}
             ^ {b[4:0], b[7:5]}
             ^ {b[1:0], b[7:2]}
             ^ c_iaff_const;
    endfunction

    logic [127:0] w_sub;
    logic [127:0] r_out_state;

    // One inverter per lane, shared by both modes through the pre/post muxes.
    for (genvar k = 0; k < 16; k++) begin : g_lane
        logic [7:0] w_in;
        logic [7:0] w_pre;
        logic [7:0] w_inv;

        assign w_in  = in_state[8*k +: 8];
        assign w_pre = fwd_ninv_i ? w_in : aff_inv(w_in);
        assign w_inv = gf_inv(w_pre);
        assign w_sub[8*k +: 8] = fwd_ninv_i ? aff_fwd(w_inv) : w_inv;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_state <= 128'h0;
        end else begin
            r_out_state <= w_sub;
        end
    end

    assign out_state = r_out_state;

endmodule

`default_nettype wire

// File: tb/tb_aes_sub_bytes.sv
// ============================================================================
//  Module   : tb_aes_sub_bytes
//  Brief    : Directed and sweep checks of aes_sub_bytes against FIPS-197.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_sub_bytes;

    logic         clk;
    logic         rst_i;
    logic         fwd_ninv_i;
    logic [127:0] in_state;
    logic [127:0] out_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] fwd_res [256];

    aes_sub_bytes u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .fwd_ninv_i (fwd_ninv_i),
        .in_state   (in_state),
        .out_state  (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box built by walking generator 3 and its inverse in lockstep.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [127:0] sweep_pattern(input int x);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(x + 16 * k);
        return v;
    endfunction

    function automatic logic [127:0] model(input logic fwd, input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = fwd ? sbox[v[8*k +: 8]] : isbox[v[8*k +: 8]];
        return r;
    endfunction

    task automatic apply(input logic mode, input logic [127:0] data);
        @(negedge clk);
        fwd_ninv_i = mode;
        in_state   = data;
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] c_pt   = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] c_sb   = 128'h638293C31BFC33F5C4EEACEA4BC12816;
    localparam logic [127:0] c_bf_i = 128'h000153FF000153FF000153FF000153FF;
    localparam logic [127:0] c_bf_o = 128'h637CED16637CED16637CED16637CED16;
    localparam logic [127:0] c_bi_i = 128'h00637C1600637C1600637C1600637C16;
    localparam logic [127:0] c_bi_o = 128'h520001FF520001FF520001FF520001FF;

    initial begin
        build_tables();
        rst_i      = 1'b0;
        fwd_ninv_i = 1'bx;
        in_state   = 'x;

        // Reset raised between edges, with undefined inputs present.
        #2 rst_i = 1'b1;
        #1 check_eq("reset_async", out_state, 128'h0);
        repeat (2) @(posedge clk);
        #1 check_eq("reset_held", out_state, 128'h0);

        @(negedge clk);
        fwd_ninv_i = 1'b1;
        in_state   = c_pt;
        rst_i      = 1'b0;
        @(posedge clk);
        #1 check_eq("first_after_reset", out_state, c_sb);

        apply(1'b0, c_sb);   check_eq("inv_fips", out_state, c_pt);
        apply(1'b1, c_pt);   check_eq("b2b_fwd", out_state, c_sb);
        apply(1'b0, c_sb);   check_eq("b2b_inv", out_state, c_pt);
        apply(1'b1, c_bf_i); check_eq("bound_fwd", out_state, c_bf_o);
        apply(1'b0, c_bi_i); check_eq("bound_inv", out_state, c_bi_o);

        for (int x = 0; x < 256; x++) begin
            apply(1'b1, sweep_pattern(x));
            fwd_res[x] = model(1'b1, sweep_pattern(x));
            check_eq($sformatf("sweep_fwd_%0d", x), out_state, fwd_res[x]);
        end
        for (int x = 0; x < 256; x++) begin
            apply(1'b0, sweep_pattern(x));
            check_eq($sformatf("sweep_inv_%0d", x), out_state, model(1'b0, sweep_pattern(x)));
        end
        for (int x = 0; x < 256; x++) begin
            apply(1'b0, fwd_res[x]);
            check_eq($sformatf("roundtrip_%0d", x), out_state, sweep_pattern(x));
        end

        // Reset mid-stream: pending result discarded, output cleared at once.
        apply(1'b1, c_pt);
        check_eq("stream_before_reset", out_state, c_sb);
        @(negedge clk);
        fwd_ninv_i = 1'b0;
        in_state   = c_sb;
        #2 rst_i = 1'b1;
        #1 check_eq("reset_mid_async", out_state, 128'h0);
        @(posedge clk);
        #1 check_eq("reset_mid_held", out_state, 128'h0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1 check_eq("release_first_edge", out_state, c_pt);
        apply(1'b1, c_bf_i); check_eq("post_reset_fwd", out_state, c_bf_o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
